// File: rtl/reg_native_pkg.sv
// rtl/reg_native_pkg.sv - shared types and width defaults for reg_native slaves
package reg_native_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } ext_mem_state_e;

endpackage

// File: rtl/ext_mem_slave.sv
// rtl/ext_mem_slave.sv - single-port memory window with reg_native req/ack handshake
import reg_native_pkg::*;

module ext_mem_slave #(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int ACK_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  ack_vld,
    input  logic                  ack_rdy,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_LOAD = 4'(ACK_LATENCY - 1);

    // Storage is deliberately left uninitialised and unreset.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    ext_mem_state_e state, state_nxt;
    logic [3:0]     cnt, cnt_nxt;
    logic           accept;

    // Handshake outputs come only from registered state.
    assign req_rdy = (state == IDLE);
    assign ack_vld = (state == ACK);
    assign accept  = req_vld && (state == IDLE);

    // Next-state and latency counter decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (ACK_LATENCY <= 1) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (cnt <= 4'd1) begin
                    state_nxt = ACK;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ACK: begin
                if (ack_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // State, counter and read-data registers; a pending ack is dropped on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rd_data <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept && !wr_en) begin
                rd_data <= rd_en ? mem[addr] : '0;
            end
        end
    end

    // Memory write port; write wins over read when both enables are set.
    always_ff @(posedge clk) begin
        if (!rst && accept && wr_en) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_ext_mem_slave.sv
// tb/tb_ext_mem_slave.sv - bench for ext_mem_slave at ack latencies 1 and 4
module tb_ext_mem_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld [2];
    logic        req_rdy [2];
    logic        wr_en   [2];
    logic        rd_en   [2];
    logic [5:0]  addr    [2];
    logic [31:0] wr_data [2];
    logic        ack_vld [2];
    logic        ack_rdy [2];
    logic [31:0] rd_data [2];

    int npass = 0;
    int ntot  = 0;
    bit run   = 1'b0;

    // Transaction-level model: pending flag, cycle at which ack shows, expected data.
    int          cyc = 0;
    bit          m_pend [2];
    int          m_ackc [2];
    logic [31:0] m_rd   [2];
    logic [31:0] m_mem  [2][64];

    always #5 clk = ~clk;

    ext_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .ACK_LATENCY(1)) u0 (
        .clk(clk), .rst(rst), .req_vld(req_vld[0]), .req_rdy(req_rdy[0]),
        .wr_en(wr_en[0]), .rd_en(rd_en[0]), .addr(addr[0]), .wr_data(wr_data[0]),
        .ack_vld(ack_vld[0]), .ack_rdy(ack_rdy[0]), .rd_data(rd_data[0])
    );

    ext_mem_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .ACK_LATENCY(4)) u1 (
        .clk(clk), .rst(rst), .req_vld(req_vld[1]), .req_rdy(req_rdy[1]),
        .wr_en(wr_en[1]), .rd_en(rd_en[1]), .addr(addr[1]), .wr_data(wr_data[1]),
        .ack_vld(ack_vld[1]), .ack_rdy(ack_rdy[1]), .rd_data(rd_data[1])
    );

    function automatic int lat(input int d);
        return (d == 1) ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Model update: acceptance in idle, completion once ack has been visible and ack_rdy is high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_pend[d] = 1'b0;
                m_rd[d]   = 32'h0;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) begin
                if (m_pend[d]) begin
                    if ((cyc - 1) >= m_ackc[d] && ack_rdy[d]) m_pend[d] = 1'b0;
                end else if (req_vld[d]) begin
                    m_pend[d] = 1'b1;
                    m_ackc[d] = cyc + lat(d) - 1;
                    if (wr_en[d]) m_mem[d][addr[d]] = wr_data[d];
                    else if (rd_en[d]) m_rd[d] = m_mem[d][addr[d]];
                    else m_rd[d] = 32'h0;
                end
            end
        end
    end

    // Every-cycle compare of the handshake and read data against the model.
    always @(negedge clk) begin
        if (run) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("req_rdy[%0d]", d), 32'(req_rdy[d]), 32'(!m_pend[d]));
                chk($sformatf("ack_vld[%0d]", d), 32'(ack_vld[d]), 32'(m_pend[d] && cyc >= m_ackc[d]));
                chk($sformatf("rd_data[%0d]", d), rd_data[d], m_rd[d]);
            end
        end
    end

    // One request: optionally disturb inputs while pending, wait for ack, hold, then complete.
    task automatic txn(input int d, input bit we, input bit re, input logic [5:0] a,
                       input logic [31:0] wd, input int hold, input bit fin, input bit poke,
                       output logic [31:0] rdv, output int edges);
        @(negedge clk);
        req_vld[d] = 1'b1; wr_en[d] = we; rd_en[d] = re; addr[d] = a; wr_data[d] = wd;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        req_vld[d] = poke; wr_en[d] = poke; rd_en[d] = 1'b0;
        addr[d] = a + 6'd1; wr_data[d] = 32'h0BAD0BAD;
        ack_rdy[d] = poke;
        for (int i = 0; i < 40 && !ack_vld[d]; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        req_vld[d] = 1'b0; wr_en[d] = 1'b0;
        rdv = rd_data[d];
        if (!ack_vld[d]) begin
            chk("ack_timeout", 32'd0, 32'd1);
            ack_rdy[d] = 1'b0;
            return;
        end
        repeat (hold) @(negedge clk);
        if (fin) begin
            ack_rdy[d] = 1'b1;
            @(posedge clk);
            @(negedge clk);
            ack_rdy[d] = 1'b0;
            chk("req_rdy_after_ack", 32'(req_rdy[d]), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        int          e;
        for (int d = 0; d < 2; d++) begin
            req_vld[d] = 0; wr_en[d] = 0; rd_en[d] = 0; addr[d] = 0;
            wr_data[d] = 0; ack_rdy[d] = 0; m_pend[d] = 0; m_rd[d] = 0; m_ackc[d] = 0;
        end
        for (int i = 0; i < 64; i++) begin
            u0.mem[i] = 32'h0; u1.mem[i] = 32'h0;
            m_mem[0][i] = 32'h0; m_mem[1][i] = 32'h0;
        end
        u0.mem[63] = 32'hA5A5A5A5;
        m_mem[0][63] = 32'hA5A5A5A5;

        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_req_rdy", 32'(req_rdy[d]), 32'd1);
            chk("reset_ack_vld", 32'(ack_vld[d]), 32'd0);
            chk("reset_rd_data", rd_data[d], 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;

        txn(0, 1, 0, 6'h05, 32'hFFFFFFFF, 0, 1, 0, v, e);
        chk("lat1_edges", 32'(e), 32'd1);
        chk("mem5", u0.mem[5], 32'hFFFFFFFF);
        txn(0, 0, 1, 6'h05, 32'h0, 0, 1, 0, v, e);
        chk("read5", v, 32'hFFFFFFFF);

        txn(0, 0, 1, 6'h3F, 32'h0, 3, 1, 0, v, e);
        chk("read3f_held", v, 32'hA5A5A5A5);

        txn(0, 1, 1, 6'h02, 32'hDEADBEEF, 0, 1, 0, v, e);
        chk("mem2_wr_prio", u0.mem[2], 32'hDEADBEEF);
        chk("rd_kept_on_write", v, 32'hA5A5A5A5);

        txn(0, 0, 0, 6'h07, 32'h12121212, 0, 1, 0, v, e);
        chk("noop_rd_zero", v, 32'h0);
        chk("noop_mem7", u0.mem[7], 32'h0);

        txn(1, 1, 0, 6'h10, 32'h12345678, 0, 1, 1, v, e);
        chk("lat4_edges", 32'(e), 32'd4);
        chk("mem10", u1.mem[16], 32'h12345678);
        chk("busy_poke_ignored", u1.mem[17], 32'h0);

        for (int a = 0; a < 64; a++) begin
            txn(1, 0, 1, 6'(a), 32'h0, 0, 1, 0, v, e);
            chk($sformatf("sweep_pre[%0d]", a), v, (a == 16) ? 32'h12345678 : 32'h0);
            txn(1, 1, 0, 6'(a), 32'hFFFFFFFF, 0, 1, 0, v, e);
            txn(1, 0, 1, 6'(a), 32'h0, 0, 1, 0, v, e);
            chk($sformatf("sweep_post[%0d]", a), v, 32'hFFFFFFFF);
        end

        txn(0, 1, 0, 6'h20, 32'h0BADF00D, 0, 1, 0, v, e);
        txn(0, 0, 1, 6'h20, 32'h0, 2, 0, 0, v, e);
        chk("pre_rst_ack", 32'(ack_vld[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_ack_vld", 32'(ack_vld[0]), 32'd0);
        chk("rst_req_rdy", 32'(req_rdy[0]), 32'd1);
        chk("rst_rd_data", rd_data[0], 32'h0);
        chk("rst_mem20", u0.mem[32], 32'h0BADF00D);
        @(negedge clk);
        rst = 1'b0;
        txn(0, 0, 1, 6'h20, 32'h0, 0, 1, 0, v, e);
        chk("post_rst_read20", v, 32'h0BADF00D);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/ext_mem_slave.md
Name: ext_mem_slave

Overview:
- Single-port synchronous memory slave with the team's reg_native handshake interface: req_vld/req_rdy for requests, ack_vld/ack_rdy for responses.
- Serves as an external memory window behind a register-slave block, one instance per external memory region.
- The upstream regslv decodes the region and presents a word index on addr.
- Storage is 2^ADDR_WIDTH words of DATA_WIDTH bits, held in an array named mem so benches can initialise and inspect it hierarchically.

Parameters:
- DATA_WIDTH, 32, width of wr_data, rd_data and each memory word.
- ADDR_WIDTH, 6, word-index width; depth = 2^ADDR_WIDTH (64 entries).
- ACK_LATENCY, 1, number of clock edges from request acceptance to ack_vld assertion; legal values 1..15.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_vld  in  1  request valid.
- req_rdy  out  1  slave ready to accept a request.
- wr_en  in  1  write request qualifier.
- rd_en  in  1  read request qualifier.
- addr  in  ADDR_WIDTH  word index; the upstream subtracts the region base and the port keeps the low ADDR_WIDTH bits.
- wr_data  in  DATA_WIDTH  write data.
- ack_vld  out  1  response valid.
- ack_rdy  in  1  upstream ready to take the response.
- rd_data  out  DATA_WIDTH  read data; valid while ack_vld=1.

Behaviour:
- FSM states:
  - IDLE: req_rdy=1.
  - BUSY: latency counter running.
  - ACK: ack_vld=1.
- req_rdy = (state==IDLE) and ack_vld = (state==ACK); both are decoded from registered state only, with no combinational path from inputs.
- Acceptance occurs on a rising edge where req_vld & req_rdy are both 1. At that edge:
  - If wr_en=1: mem[addr] <= wr_data. Write has priority when wr_en and rd_en are both 1.
  - Else if rd_en=1: rd_data <= mem[addr].
  - If neither is set: no memory change, rd_data <= 0; the request is still acknowledged.
- Transitions after acceptance:
  - ACK_LATENCY=1: IDLE -> ACK, so ack_vld is high in the cycle following acceptance.
  - ACK_LATENCY>1: IDLE -> BUSY, with the counter loaded to ACK_LATENCY-1. BUSY decrements each edge and moves to ACK when the counter reaches 1.
- In ACK:
  - ack_vld and rd_data are held stable indefinitely until ack_rdy=1 at a rising edge.
  - On that edge the state returns to IDLE and rd_data is retained.
  - ack_rdy asserted early, before or during BUSY, is legal and has no effect until ACK.
- Sequencing:
  - A new request can be accepted at the earliest one cycle after the ACK-completing edge.
  - No request is accepted while BUSY or ACK.
  - Request inputs are ignored outside IDLE, so upstream may drop or keep req_vld after acceptance.
- Reset (rst=1, asynchronous):
  - State returns to IDLE, counter = 0, ack_vld = 0, rd_data = 0, req_rdy = 1 after reset.
  - Memory contents are not reset and are not initialised by RTL.
  - A write accepted before reset stays committed; a pending ack is discarded.
- Address range: wraps modulo 2^ADDR_WIDTH; no out-of-range error response exists.
- Read after write to the same address in consecutive transactions returns the new data.

Decomposition:
- Shared package reg_native_pkg:
  - enum ext_mem_state_e {IDLE, BUSY, ACK}.
  - Default width constants: DATA_WIDTH 32, ADDR_WIDTH 6.
- A sub-module is not required. An optional leaf, sp_ram (a plain synchronous single-port array with write-enable and registered read), is natural if the team wants to swap in a macro later; mem must stay hierarchically reachable as ext_mem_slave.mem or sp_ram.mem.

Test Plan:
- Reset, then backdoor-fill mem with 0; write addr=0x05 data=0xFFFFFFFF, then read addr=0x05:
  - req_rdy drops the cycle after acceptance.
  - ack_vld rises one cycle after acceptance.
  - Read returns rd_data=0xFFFFFFFF; mem[5]=0xFFFFFFFF.
- Delayed ack_rdy: hold ack_rdy=0 for 3 cycles after ack_vld, with a read of addr=0x3F that was preloaded with 0xA5A5A5A5:
  - ack_vld and rd_data=0xA5A5A5A5 stay stable through the wait.
  - Completion happens on the ack_rdy edge; req_rdy=1 in the next cycle.
- ACK_LATENCY=4: write 0x12345678 to addr=0x10:
  - ack_vld asserts exactly 4 edges after acceptance.
  - Changes on req_vld and wr_en during BUSY are ignored.
- Sweep all 64 addresses, writing 0xFFFFFFFF then reading each back:
  - Every read returns 0xFFFFFFFF.
  - Addresses not yet written still read 0 from the backdoor init.
- wr_en=rd_en=1 at addr=0x02 with data 0xDEADBEEF: mem[2]=0xDEADBEEF.
- Request with neither enable set: ack with rd_data=0 and no mem change.
- Assert rst while in ACK:
  - ack_vld=0 and req_rdy=1 immediately, asynchronously.
  - A previously accepted write remains in mem.
